// File: rtl/multicycle_control_if.sv
// multicycle_control_if
//   Groups the IR fields and flags that feed the multi-cycle sequencer, together
//   with every datapath control line it drives.
//
//   Parameter:
//     STATE_W   width of the debug State bus
//
//   Signals:
//     Op, Func, Zero, MemReady              -> into the controller
//     PCWrite .. PCSrc                      -> datapath muxes and enables
//     InstrDone, Illegal, BusErr, State     -> status and debug
//
//   Modports:
//     master : the controller (drives control lines, reads IR fields)
//     slave  : the datapath side (drives IR fields and flags, reads controls)
interface multicycle_control_if #(
  parameter int STATE_W = 4
);
  logic [5:0]         Op;
  logic [5:0]         Func;
  logic               Zero;
  logic               MemReady;

  logic               PCWrite;
  logic               PCWriteCond;
  logic               IorD;
  logic               MemRead;
  logic               MemWrite;
  logic               IRWrite;
  logic               RegDst;
  logic               WriteRA;
  logic               MemtoReg;
  logic               RegWrite;
  logic               ALUSrcA;
  logic [1:0]         ALUSrcB;
  logic [4:0]         ALUop;
  logic [1:0]         Ext;
  logic [1:0]         PCSrc;
  logic               InstrDone;
  logic               Illegal;
  logic               BusErr;
  logic [STATE_W-1:0] State;

  modport master (
    input  Op, Func, Zero, MemReady,
    output PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
           RegDst, WriteRA, MemtoReg, RegWrite, ALUSrcA, ALUSrcB,
           ALUop, Ext, PCSrc, InstrDone, Illegal, BusErr, State
  );

  modport slave (
    output Op, Func, Zero, MemReady,
    input  PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
           RegDst, WriteRA, MemtoReg, RegWrite, ALUSrcA, ALUSrcB,
           ALUop, Ext, PCSrc, InstrDone, Illegal, BusErr, State
  );
endinterface

// File: rtl/multicycle_control.sv
// multicycle_control
//   Moore sequencer for the multi-cycle MIPS datapath. Each instruction walks
//   through FETCH, DECODE and then an execute / memory / writeback path chosen
//   by the opcode; every datapath mux select and enable is decoded from the
//   current state (Op/Func only refine a few fields and are held by the IR).
//
//   Parameters:
//     STATE_W   width of the debug State output
//     MAX_WAIT  memory wait cycles allowed before a bus error (MEM_WAIT_EN only)
//
//   Ports:
//     clk    rising-edge clock
//     rst_n  asynchronous active-low reset; state returns to FETCH and all
//            control outputs are held low while it is asserted
//     bus    multicycle_control_if.master (IR fields in, control lines out)
//
//   Optional feature, macro MEM_WAIT_EN:
//     FETCH, MEMRD and MEMWR stall until MemReady; a 4-bit wait counter that
//     clears on every state entry raises a sticky BusErr after MAX_WAIT cycles
//     without MemReady and sends the FSM back to FETCH. Without the macro the
//     memory is single-cycle, MemReady is ignored and BusErr is 0.
module multicycle_control #(
  parameter int STATE_W  = 4,
  parameter int MAX_WAIT = 15
) (
  input  logic                  clk,
  input  logic                  rst_n,
  multicycle_control_if.master  bus
);

  // ALU operation codes
  localparam logic [4:0] ALU_NOP  = 5'd0;
  localparam logic [4:0] ALU_ADD  = 5'd1;
  localparam logic [4:0] ALU_ADDU = 5'd2;
  localparam logic [4:0] ALU_SUB  = 5'd3;
  localparam logic [4:0] ALU_SUBU = 5'd4;
  localparam logic [4:0] ALU_AND  = 5'd5;
  localparam logic [4:0] ALU_OR   = 5'd6;
  localparam logic [4:0] ALU_XOR  = 5'd7;
  localparam logic [4:0] ALU_NOR  = 5'd8;
  localparam logic [4:0] ALU_SLT  = 5'd9;
  localparam logic [4:0] ALU_SLTU = 5'd10;
  localparam logic [4:0] ALU_SLL  = 5'd11;
  localparam logic [4:0] ALU_SRL  = 5'd12;
  localparam logic [4:0] ALU_SRA  = 5'd13;
  localparam logic [4:0] ALU_SLLV = 5'd14;
  localparam logic [4:0] ALU_SRLV = 5'd15;
  localparam logic [4:0] ALU_SRAV = 5'd16;

  // Extender modes
  localparam logic [1:0] EXT_ZERO   = 2'd0;
  localparam logic [1:0] EXT_SIGNED = 2'd1;

  // Next-PC selects
  localparam logic [1:0] NPC_PLUS4  = 2'd0;
  localparam logic [1:0] NPC_BRANCH = 2'd1;
  localparam logic [1:0] NPC_JUMP   = 2'd2;
  localparam logic [1:0] NPC_JAL    = 2'd3;

  // Opcodes
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    EXEC_R = 4'd2,
    EXEC_I = 4'd3,
    MEMADR = 4'd4,
    MEMRD  = 4'd5,
    MEMWB  = 4'd6,
    MEMWR  = 4'd7,
    BRANCH = 4'd8,
    JUMP   = 4'd9,
    ALUWB  = 4'd10
  } state_t;

  state_t state;
  state_t state_next;

  // R-type function decode: bit 5 flags a supported Func, bits 4:0 the ALU op.
  function automatic logic [5:0] r_decode(input logic [5:0] f);
    case (f)
      6'h20:   r_decode = {1'b1, ALU_ADD};
      6'h21:   r_decode = {1'b1, ALU_ADDU};
      6'h22:   r_decode = {1'b1, ALU_SUB};
      6'h23:   r_decode = {1'b1, ALU_SUBU};
      6'h24:   r_decode = {1'b1, ALU_AND};
      6'h25:   r_decode = {1'b1, ALU_OR};
      6'h26:   r_decode = {1'b1, ALU_XOR};
      6'h27:   r_decode = {1'b1, ALU_NOR};
      6'h2A:   r_decode = {1'b1, ALU_SLT};
      6'h2B:   r_decode = {1'b1, ALU_SLTU};
      6'h00:   r_decode = {1'b1, ALU_SLL};
      6'h02:   r_decode = {1'b1, ALU_SRL};
      6'h03:   r_decode = {1'b1, ALU_SRA};
      6'h04:   r_decode = {1'b1, ALU_SLLV};
      6'h06:   r_decode = {1'b1, ALU_SRLV};
      6'h07:   r_decode = {1'b1, ALU_SRAV};
      default: r_decode = {1'b0, ALU_NOP};
    endcase
  endfunction

  logic [5:0] r_info;
  assign r_info = r_decode(bus.Func);

`ifdef MEM_WAIT_EN
  localparam logic [3:0] WAIT_LAST = 4'(MAX_WAIT - 1);

  logic [3:0] wait_cnt;
  logic       wait_last;
  logic       timeout;
  logic       bus_err;
  logic       unused_in;

  assign wait_last  = (wait_cnt == WAIT_LAST);
  assign bus.BusErr = bus_err;
  assign unused_in  = bus.Zero;

  // Wait counter restarts whenever the FSM enters a state (including a
  // timeout that re-enters FETCH), so it only measures the current stall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      wait_cnt <= 4'd0;
    else if ((state_next != state) || timeout)
      wait_cnt <= 4'd0;
    else
      wait_cnt <= wait_cnt + 4'd1;
  end

  // Bus error is sticky until the next reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      bus_err <= 1'b0;
    else if (timeout)
      bus_err <= 1'b1;
  end
`else
  logic unused_in;

  // Zero is consumed by the datapath's PC-write gate, MemReady only matters
  // with wait states, so they are intentionally not read here.
  assign bus.BusErr = 1'b0;
  assign unused_in  = bus.Zero ^ bus.MemReady ^ (MAX_WAIT > 0);
`endif

  assign bus.State = STATE_W'(state);

  // State register; reset lands in FETCH immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= FETCH;
    else
      state <= state_next;
  end

  // Next-state and output decode. Every output starts at its idle value and
  // each state only overrides what it needs. While rst_n is low the case is
  // skipped so no strobe can fire during reset.
  always_comb begin
    state_next      = FETCH;
    bus.PCWrite     = 1'b0;
    bus.PCWriteCond = 1'b0;
    bus.IorD        = 1'b0;
    bus.MemRead     = 1'b0;
    bus.MemWrite    = 1'b0;
    bus.IRWrite     = 1'b0;
    bus.RegDst      = 1'b0;
    bus.WriteRA     = 1'b0;
    bus.MemtoReg    = 1'b0;
    bus.RegWrite    = 1'b0;
    bus.ALUSrcA     = 1'b0;
    bus.ALUSrcB     = 2'd0;
    bus.ALUop       = ALU_NOP;
    bus.Ext         = EXT_ZERO;
    bus.PCSrc       = NPC_PLUS4;
    bus.InstrDone   = 1'b0;
    bus.Illegal     = 1'b0;
`ifdef MEM_WAIT_EN
    timeout         = 1'b0;
`endif

    if (rst_n) begin
      case (state)
        FETCH: begin
          bus.MemRead = 1'b1;
          bus.ALUSrcB = 2'd1;
          bus.ALUop   = ALU_ADDU;
`ifdef MEM_WAIT_EN
          // PC and IR must load exactly once, on the cycle the read lands.
          bus.PCWrite = bus.MemReady;
          bus.IRWrite = bus.MemReady;
          if (bus.MemReady)
            state_next = DECODE;
          else begin
            state_next = FETCH;
            timeout    = wait_last;
          end
`else
          bus.PCWrite = 1'b1;
          bus.IRWrite = 1'b1;
          state_next  = DECODE;
`endif
        end

        DECODE: begin
          // ALU speculatively forms the branch target PC + (imm << 2).
          bus.ALUSrcB = 2'd3;
          bus.ALUop   = ALU_ADDU;
          bus.Ext     = EXT_SIGNED;
          case (bus.Op)
            OP_RTYPE: begin
              if (r_info[5])
                state_next = EXEC_R;
              else begin
                state_next  = FETCH;
                bus.Illegal = 1'b1;
              end
            end
            OP_ADDI:        state_next = EXEC_I;
            OP_LW, OP_SW:   state_next = MEMADR;
            OP_BEQ:         state_next = BRANCH;
            OP_J, OP_JAL:   state_next = JUMP;
            default: begin
              state_next  = FETCH;
              bus.Illegal = 1'b1;
            end
          endcase
        end

        EXEC_R: begin
          bus.ALUSrcA = 1'b1;
          bus.ALUop   = r_info[4:0];
          state_next  = ALUWB;
        end

        EXEC_I: begin
          bus.ALUSrcA = 1'b1;
          bus.ALUSrcB = 2'd2;
          bus.Ext     = EXT_SIGNED;
          bus.ALUop   = ALU_ADD;
          state_next  = ALUWB;
        end

        ALUWB: begin
          // Destination is rd for R-type, rt for addi.
          bus.RegWrite  = 1'b1;
          bus.RegDst    = (bus.Op == OP_RTYPE);
          bus.InstrDone = 1'b1;
          state_next    = FETCH;
        end

        MEMADR: begin
          bus.ALUSrcA = 1'b1;
          bus.ALUSrcB = 2'd2;
          bus.Ext     = EXT_SIGNED;
          bus.ALUop   = ALU_ADD;
          state_next  = (bus.Op == OP_SW) ? MEMWR : MEMRD;
        end

        MEMRD: begin
          bus.MemRead = 1'b1;
          bus.IorD    = 1'b1;
`ifdef MEM_WAIT_EN
          if (bus.MemReady)
            state_next = MEMWB;
          else if (wait_last) begin
            state_next = FETCH;
            timeout    = 1'b1;
          end else
            state_next = MEMRD;
`else
          state_next  = MEMWB;
`endif
        end

        MEMWB: begin
          bus.RegWrite  = 1'b1;
          bus.MemtoReg  = 1'b1;
          bus.InstrDone = 1'b1;
          state_next    = FETCH;
        end

        MEMWR: begin
          bus.MemWrite = 1'b1;
          bus.IorD     = 1'b1;
`ifdef MEM_WAIT_EN
          // Store only retires once the memory accepts it.
          bus.InstrDone = bus.MemReady;
          if (bus.MemReady)
            state_next = FETCH;
          else if (wait_last) begin
            state_next = FETCH;
            timeout    = 1'b1;
          end else
            state_next = MEMWR;
`else
          bus.InstrDone = 1'b1;
          state_next    = FETCH;
`endif
        end

        BRANCH: begin
          // rs - rt drives Zero; the datapath loads PC only when it is set.
          bus.ALUSrcA     = 1'b1;
          bus.ALUop       = ALU_SUB;
          bus.PCWriteCond = 1'b1;
          bus.PCSrc       = NPC_BRANCH;
          bus.InstrDone   = 1'b1;
          state_next      = FETCH;
        end

        JUMP: begin
          bus.PCWrite   = 1'b1;
          bus.InstrDone = 1'b1;
          if (bus.Op == OP_JAL) begin
            bus.PCSrc    = NPC_JAL;
            bus.WriteRA  = 1'b1;
            bus.RegWrite = 1'b1;
          end else
            bus.PCSrc    = NPC_JUMP;
          state_next = FETCH;
        end

        // Codes 11..15 carry no outputs and recover to FETCH.
        default: state_next = FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control
//   Self-checking bench for multicycle_control. A stimulus process plays the
//   role of the IR, issuing one instruction at a time and pushing the expected
//   per-instruction outcome (state trace, latency, strobe counts, writeback
//   selects) into a scoreboard queue. A monitor process watches the control
//   lines every cycle and compares against the queue whenever an instruction
//   retires (InstrDone) or is rejected (Illegal).
//   Directed checks cover reset, reset abort mid-MEMRD and, with MEM_WAIT_EN,
//   memory stalls and the bus-error timeout.
module tb_multicycle_control;

  localparam int STATE_W = 4;

  localparam logic [4:0] ALU_NOP  = 5'd0;
  localparam logic [4:0] ALU_ADD  = 5'd1;
  localparam logic [4:0] ALU_ADDU = 5'd2;
  localparam logic [4:0] ALU_SUB  = 5'd3;
  localparam logic [4:0] ALU_SUBU = 5'd4;
  localparam logic [4:0] ALU_AND  = 5'd5;
  localparam logic [4:0] ALU_OR   = 5'd6;
  localparam logic [4:0] ALU_XOR  = 5'd7;
  localparam logic [4:0] ALU_NOR  = 5'd8;
  localparam logic [4:0] ALU_SLT  = 5'd9;
  localparam logic [4:0] ALU_SLTU = 5'd10;
  localparam logic [4:0] ALU_SLL  = 5'd11;
  localparam logic [4:0] ALU_SRL  = 5'd12;
  localparam logic [4:0] ALU_SRA  = 5'd13;
  localparam logic [4:0] ALU_SLLV = 5'd14;
  localparam logic [4:0] ALU_SRLV = 5'd15;
  localparam logic [4:0] ALU_SRAV = 5'd16;

  localparam logic [1:0] NPC_PLUS4  = 2'd0;
  localparam logic [1:0] NPC_BRANCH = 2'd1;
  localparam logic [1:0] NPC_JUMP   = 2'd2;
  localparam logic [1:0] NPC_JAL    = 2'd3;

  // What one instruction is expected to do over its whole lifetime.
  typedef struct {
    int         lat;
    logic [19:0] trace;
    int         n_rw;
    int         n_mw;
    int         n_mr;
    int         n_pcw;
    int         n_pcwc;
    int         n_irw;
    int         n_ill;
    int         n_done;
    logic       wb_dst;
    logic       wb_mem;
    logic       wb_ra;
    logic [4:0] alu3;
    logic [1:0] pcsrc;
  } rec_t;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  bit   mon_en = 1'b0;
  rec_t exp_q[$];

  always #5 clk = ~clk;

  multicycle_control_if #(.STATE_W(STATE_W)) bus ();

  multicycle_control #(.STATE_W(STATE_W), .MAX_WAIT(15)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master)
  );

  task automatic check_output(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Supported R-type functions and the ALU operation each one selects.
  function automatic logic [4:0] ref_alu(input logic [5:0] f, output bit ok);
    ok = 1'b1;
    case (f)
      6'h20: return ALU_ADD;
      6'h21: return ALU_ADDU;
      6'h22: return ALU_SUB;
      6'h23: return ALU_SUBU;
      6'h24: return ALU_AND;
      6'h25: return ALU_OR;
      6'h26: return ALU_XOR;
      6'h27: return ALU_NOR;
      6'h2A: return ALU_SLT;
      6'h2B: return ALU_SLTU;
      6'h00: return ALU_SLL;
      6'h02: return ALU_SRL;
      6'h03: return ALU_SRA;
      6'h04: return ALU_SLLV;
      6'h06: return ALU_SRLV;
      6'h07: return ALU_SRAV;
      default: begin
        ok = 1'b0;
        return ALU_NOP;
      end
    endcase
  endfunction

  // Instruction-level reference: the path of states, how many of each strobe
  // fire, and what the writeback / next-PC selects look like on retirement.
  function automatic rec_t ref_model(input logic [5:0] op, input logic [5:0] func);
    rec_t       r;
    logic [3:0] st[$];
    bit         ok;
    logic [4:0] a;
    r = '{default: 0};
    st = {4'd0, 4'd1};
    r.n_mr  = 1;
    r.n_pcw = 1;
    r.n_irw = 1;
    r.alu3  = ALU_NOP;
    r.pcsrc = NPC_PLUS4;
    case (op)
      6'h00: begin
        a = ref_alu(func, ok);
        if (ok) begin
          st.push_back(4'd2); st.push_back(4'd10);
          r.n_rw = 1; r.wb_dst = 1'b1; r.alu3 = a; r.n_done = 1;
        end else
          r.n_ill = 1;
      end
      6'h08: begin
        st.push_back(4'd3); st.push_back(4'd10);
        r.n_rw = 1; r.alu3 = ALU_ADD; r.n_done = 1;
      end
      6'h23: begin
        st.push_back(4'd4); st.push_back(4'd5); st.push_back(4'd6);
        r.n_rw = 1; r.wb_mem = 1'b1; r.n_mr = 2; r.alu3 = ALU_ADD; r.n_done = 1;
      end
      6'h2B: begin
        st.push_back(4'd4); st.push_back(4'd7);
        r.n_mw = 1; r.alu3 = ALU_ADD; r.n_done = 1;
      end
      6'h04: begin
        st.push_back(4'd8);
        r.n_pcwc = 1; r.alu3 = ALU_SUB; r.pcsrc = NPC_BRANCH; r.n_done = 1;
      end
      6'h02: begin
        st.push_back(4'd9);
        r.n_pcw = 2; r.pcsrc = NPC_JUMP; r.n_done = 1;
      end
      6'h03: begin
        st.push_back(4'd9);
        r.n_pcw = 2; r.n_rw = 1; r.wb_ra = 1'b1; r.pcsrc = NPC_JAL; r.n_done = 1;
      end
      default: r.n_ill = 1;
    endcase
    r.lat   = st.size();
    r.trace = '0;
    foreach (st[i]) r.trace = {r.trace[15:0], st[i]};
    return r;
  endfunction

  // Called during a FETCH cycle (just after the active edge); holds the
  // instruction in the "IR" for exactly the modelled latency.
  task automatic apply_stimulus(input logic [5:0] op, input logic [5:0] func, input logic zero);
    rec_t r;
    r = ref_model(op, func);
    bus.Op   = op;
    bus.Func = func;
    bus.Zero = zero;
    exp_q.push_back(r);
    repeat (r.lat) @(posedge clk);
    #1;
  endtask

  // Monitor: accumulate one instruction's behaviour, compare on retirement.
  initial begin
    rec_t act;
    rec_t e;
    act = '{default: 0};
    forever begin
      @(negedge clk);
      if (!mon_en) begin
        act = '{default: 0};
        continue;
      end
      act.lat++;
      act.trace = {act.trace[15:0], bus.State};
      if (bus.RegWrite) begin
        act.n_rw++;
        act.wb_dst |= bus.RegDst;
        act.wb_mem |= bus.MemtoReg;
        act.wb_ra  |= bus.WriteRA;
      end
      if (bus.MemWrite)    act.n_mw++;
      if (bus.MemRead)     act.n_mr++;
      if (bus.PCWrite)     act.n_pcw++;
      if (bus.PCWriteCond) act.n_pcwc++;
      if (bus.IRWrite)     act.n_irw++;
      if (bus.Illegal)     act.n_ill++;
      if (bus.InstrDone)   act.n_done++;
      if (act.lat == 3)    act.alu3 = bus.ALUop;
      if (bus.InstrDone || bus.Illegal) begin
        act.pcsrc = bus.PCSrc;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_retire: got trace %h with no instruction pending", act.trace);
        end else begin
          e = exp_q.pop_front();
          check_output("latency",     act.lat,    e.lat);
          check_output("state_trace", act.trace,  e.trace);
          check_output("regwrite",    act.n_rw,   e.n_rw);
          check_output("memwrite",    act.n_mw,   e.n_mw);
          check_output("memread",     act.n_mr,   e.n_mr);
          check_output("pcwrite",     act.n_pcw,  e.n_pcw);
          check_output("pcwritecond", act.n_pcwc, e.n_pcwc);
          check_output("irwrite",     act.n_irw,  e.n_irw);
          check_output("illegal",     act.n_ill,  e.n_ill);
          check_output("instrdone",   act.n_done, e.n_done);
          check_output("regdst",      act.wb_dst, e.wb_dst);
          check_output("memtoreg",    act.wb_mem, e.wb_mem);
          check_output("writera",     act.wb_ra,  e.wb_ra);
          check_output("exec_aluop",  act.alu3,   e.alu3);
          check_output("retire_pcsrc", act.pcsrc, e.pcsrc);
        end
        act = '{default: 0};
      end else if (act.lat >= 8) begin
        checks++;
        errors++;
        $display("[TB] FAIL retire_timeout: got %0d cycles without retirement, required at most 5", act.lat);
        act = '{default: 0};
      end
    end
  end

  // Global watchdog so a stuck run still ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got simulation time limit, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [5:0] ops[7];
    logic [5:0] rfuncs[16];
    logic [5:0] op;
    logic [5:0] func;

    ops    = '{6'h00, 6'h08, 6'h23, 6'h2B, 6'h04, 6'h02, 6'h03};
    rfuncs = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
               6'h2A, 6'h2B, 6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07};

    rst_n        = 1'b0;
    bus.Op       = 6'h00;
    bus.Func     = 6'h00;
    bus.Zero     = 1'b0;
    bus.MemReady = 1'b1;

    // Reset: FETCH state with every strobe held low.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_output("reset_state",   bus.State,   0);
    check_output("reset_memread", bus.MemRead, 0);
    check_output("reset_pcwrite", bus.PCWrite, 0);
    check_output("reset_irwrite", bus.IRWrite, 0);

    // Release and run an lw into MEMRD, then abort it with reset.
    @(posedge clk); #1;
    rst_n  = 1'b1;
    bus.Op = 6'h23;
    @(negedge clk);
    check_output("fetch_state",   bus.State,   0);
    check_output("fetch_memread", bus.MemRead, 1);
    check_output("fetch_alusrcb", bus.ALUSrcB, 1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_output("memrd_state", bus.State, 5);
    check_output("memrd_iord",  bus.IorD,  1);
    #1 rst_n = 1'b0;
    #1;
    check_output("abort_state",    bus.State,    0);
    check_output("abort_regwrite", bus.RegWrite, 0);
    check_output("abort_memread",  bus.MemRead,  0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check_output("post_abort_state", bus.State, 0);
    @(negedge clk);
    check_output("post_abort_next",  bus.State, 1);

    // Clean restart, then the scoreboarded instruction stream.
    @(posedge clk); #1 rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    mon_en = 1'b1;

    apply_stimulus(6'h00, 6'h20, 1'b0);
    apply_stimulus(6'h23, 6'h00, 1'b0);
    apply_stimulus(6'h2B, 6'h00, 1'b0);
    apply_stimulus(6'h04, 6'h00, 1'b1);
    apply_stimulus(6'h04, 6'h00, 1'b0);
    apply_stimulus(6'h03, 6'h00, 1'b0);
    apply_stimulus(6'h3F, 6'h00, 1'b0);
    apply_stimulus(6'h08, 6'h00, 1'b0);
    apply_stimulus(6'h02, 6'h00, 1'b0);
    apply_stimulus(6'h00, 6'h01, 1'b0);
    apply_stimulus(6'h00, 6'h07, 1'b1);

    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(0, 7) == 0)
        op = 6'($urandom_range(0, 63));
      else
        op = ops[$urandom_range(0, 6)];
      if ($urandom_range(0, 7) == 0)
        func = 6'($urandom_range(0, 63));
      else
        func = rfuncs[$urandom_range(0, 15)];
      apply_stimulus(op, func, 1'($urandom_range(0, 1)));
    end

    mon_en = 1'b0;
    check_output("scoreboard_drained", exp_q.size(), 0);

`ifdef MEM_WAIT_EN
    // Three stalled FETCH cycles, then PC/IR load once on the fourth.
    @(posedge clk); #1;
    rst_n        = 1'b0;
    bus.MemReady = 1'b0;
    bus.Op       = 6'h02;
    @(posedge clk); #1 rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_output("stall_state",   bus.State,   0);
      check_output("stall_pcwrite", bus.PCWrite, 0);
      check_output("stall_irwrite", bus.IRWrite, 0);
    end
    @(posedge clk); #1 bus.MemReady = 1'b1;
    @(negedge clk);
    check_output("ready_state",   bus.State,   0);
    check_output("ready_pcwrite", bus.PCWrite, 1);
    check_output("ready_irwrite", bus.IRWrite, 1);
    @(negedge clk);
    check_output("ready_next", bus.State, 1);

    // MemReady never arrives: BusErr after 15 FETCH cycles.
    @(posedge clk); #1;
    rst_n        = 1'b0;
    bus.MemReady = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (14) @(posedge clk);
    @(negedge clk);
    check_output("buserr_before", bus.BusErr, 0);
    @(negedge clk);
    check_output("buserr_after",  bus.BusErr, 1);
    check_output("buserr_state",  bus.State,  0);
`else
    check_output("buserr_tied", bus.BusErr, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Multi-cycle sequencer for the MIPS datapath. Replaces the single-cycle decoder once the core moves to a shared instruction/data memory and a single ALU reused across cycles.
- Holds a Moore FSM that steps each instruction through fetch, decode, execute, memory and writeback. Drives every datapath mux and enable, using the ALU and extender encodings defined in ENCODE.v.
- Sits between the IR (it consumes Op and Func) and the datapath register enables.

Parameters:
- STATE_W, 4, width of the state register.
- MAX_WAIT, 15, max memory wait cycles before a bus error (used only with MEM_WAIT_EN).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset. One clock; reset is asynchronous and active-low.
- Op  in  6  IR[31:26].
- Func  in  6  IR[5:0].
- Zero  in  1  ALU zero flag.
- MemReady  in  1  memory access complete (used only with MEM_WAIT_EN).
- PCWrite  out  1  unconditional PC load.
- PCWriteCond  out  1  PC load if Zero.
- IorD  out  1  memory address: 0 = PC, 1 = ALUOut.
- MemRead  out  1  memory read strobe.
- MemWrite  out  1  memory write strobe.
- IRWrite  out  1  IR load.
- RegDst  out  1  1 = rd, 0 = rt.
- WriteRA  out  1  write $31 with PC (jal).
- MemtoReg  out  1  writeback source: 1 = MDR, 0 = ALUOut.
- RegWrite  out  1  register file write enable.
- ALUSrcA  out  1  0 = PC, 1 = rs.
- ALUSrcB  out  2  0 = rt, 1 = const 4, 2 = ext imm, 3 = ext imm<<2.
- ALUop  out  5  ALU operation, ENCODE.v ALU_* codes.
- Ext  out  2  extender mode, EXT_* codes.
- PCSrc  out  2  NPC_* codes.
- InstrDone  out  1  one-cycle pulse when an instruction retires.
- Illegal  out  1  one-cycle pulse for an unsupported Op or Func.
- BusErr  out  1  sticky wait timeout (MEM_WAIT_EN only; tied 0 otherwise).
- State  out  STATE_W  current state, for debug.

Behaviour:
- States and codes: FETCH 0, DECODE 1, EXEC_R 2, EXEC_I 3, MEMADR 4, MEMRD 5, MEMWB 6, MEMWR 7, BRANCH 8, JUMP 9, ALUWB 10. Codes 11–15 are unused and recover to FETCH on the next clock.
- All outputs are a pure decode of State (Moore). Every output is 0 / ALU_NOP / EXT_ZERO / NPC_PLUS4 unless listed for a state below.
- Reset: State = FETCH asynchronously and all strobes are low. FETCH outputs become visible once rst_n deasserts.
- FETCH: MemRead=1, IorD=0, IRWrite=1, ALUSrcA=0, ALUSrcB=1, ALUop=ALU_ADDU, PCWrite=1, PCSrc=NPC_PLUS4. Next state: DECODE.
- DECODE: ALUSrcA=0, ALUSrcB=3, ALUop=ALU_ADDU, Ext=EXT_SIGNED (branch target precompute). Next state by Op:
  - R (0x00) with a supported Func → EXEC_R.
  - addi 0x08 → EXEC_I.
  - lw 0x23 / sw 0x2B → MEMADR.
  - beq 0x04 → BRANCH.
  - j 0x02 / jal 0x03 → JUMP.
  - anything else → FETCH with Illegal=1 that cycle.
- EXEC_R: ALUSrcA=1, ALUSrcB=0, ALUop from Func (add, addu, and, sub, subu, nor, or, xor, slt, sltu, sll, srl, sra, sllv, srlv, srav → matching ALU_* code). Next state: ALUWB.
- EXEC_I: ALUSrcA=1, ALUSrcB=2, Ext=EXT_SIGNED, ALUop=ALU_ADD. Next state: ALUWB.
- ALUWB: RegWrite=1, MemtoReg=0, RegDst=1 for R-type and 0 for addi (Op is held stable by the IR). InstrDone=1. Next state: FETCH.
- MEMADR: ALUSrcA=1, ALUSrcB=2, Ext=EXT_SIGNED, ALUop=ALU_ADD. Next state: MEMRD for lw, MEMWR for sw.
- MEMRD: MemRead=1, IorD=1. Next state: MEMWB.
- MEMWB: RegWrite=1, MemtoReg=1, RegDst=0, InstrDone=1. Next state: FETCH.
- MEMWR: MemWrite=1, IorD=1, InstrDone=1. Next state: FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=0, ALUop=ALU_SUB, PCWriteCond=1, PCSrc=NPC_BRANCH, InstrDone=1. Next state: FETCH.
- JUMP: PCWrite=1, PCSrc = NPC_JUMP for j or NPC_JAL for jal. For jal also WriteRA=1 and RegWrite=1. InstrDone=1. Next state: FETCH.
- Instruction latency in cycles: R/addi 4, lw 5, sw 4, beq 3, j/jal 3.
- Op/Func are sampled only in DECODE, MEMADR, EXEC_R, ALUWB and JUMP. They are stable because IRWrite is asserted only in FETCH.
- rst_n asserted mid-instruction aborts it immediately: no further writes, next active state is FETCH.

Optional Feature:
- Macro: MEM_WAIT_EN.
- With the macro defined:
  - FETCH, MEMRD and MEMWR hold their state and outputs until MemReady=1.
  - PCWrite and IRWrite in FETCH are gated by MemReady so PC and IR load exactly once.
  - A 4-bit wait counter clears on each state entry.
  - If the counter reaches MAX_WAIT without MemReady: BusErr sets (sticky until reset) and the FSM returns to FETCH with no register or memory write.
- Without the macro: memory is treated as single-cycle, MemReady is ignored, and BusErr is tied to 0.

Test Plan:
- Reset with rst_n=0 mid-MEMRD, then release → State=0, RegWrite=0; next cycle State=1.
- Op=0x00, Func=0x20 (add) → states 0,1,2,10,0; ALUop=ALU_ADD in EXEC_R; RegWrite=1 and RegDst=1 only in cycle 4; one InstrDone pulse.
- Op=0x23 (lw) then Op=0x2B (sw) → lw: 5 cycles with MemtoReg=1 in MEMWB; sw: 4 cycles, MemWrite=1 exactly once, RegWrite never asserted.
- Op=0x04 (beq) with Zero=1, then Zero=0 → PCWriteCond=1 in cycle 3, PCSrc=NPC_BRANCH both times; total 3 cycles each.
- Op=0x03 (jal) → JUMP asserts PCWrite, WriteRA, RegWrite and PCSrc=NPC_JAL; Op=0x3F → Illegal pulse in DECODE, no writes, back to FETCH.
- MEM_WAIT_EN: MemReady low for 3 cycles in FETCH → 4 FETCH cycles, PCWrite/IRWrite high only in the last one. MemReady never high → BusErr=1 after 15 cycles.
